elevator_car_model: RTL and testbench

//  Cycle-level plant model of one elevator car and shaft: consumes the controller's motor/door

---
 rtl/elevator_car_model.sv | 184 ++++++++++++++++++
 tb/tb_elevator_car_model.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_model.sv
// Cycle-level plant model of one elevator car: turns motor/door commands into floor sensors and door status.
// Optional ELEVATOR_FLOOR_GAP_EN: floor_sensor reads zero while the car is between floors.
module elevator_car_model #(
  parameter int N             = 8,
  parameter int TRAVEL_CYCLES = 16,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                motor_up,
  input  logic                                motor_down,
  input  logic                                open_door,
  input  logic                                close_door,
  output logic [N-1:0]                        floor_sensor,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] car_floor,
  output logic                                door_open,
  output logic                                door_closed,
  output logic                                moving,
  output logic                                fault
);

  localparam int PW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [PW-1:0] TOP_FLOOR = PW'(N - 1);
  localparam logic [CW-1:0] T_LOAD    = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] D_LOAD    = CW'(DOOR_CYCLES - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] MOVE_UP   = 3'd1;
  localparam logic [2:0] MOVE_DOWN = 3'd2;
  localparam logic [2:0] OPENING   = 3'd3;
  localparam logic [2:0] OPENED    = 3'd4;
  localparam logic [2:0] CLOSING   = 3'd5;

  logic [2:0]    state_reg, state_next;
  logic [CW-1:0] tcnt_reg, tcnt_next;
  logic [CW-1:0] dcnt_reg, dcnt_next;
  logic [PW-1:0] car_floor_reg, car_floor_next;
  logic          door_open_reg, door_open_next;
  logic          door_closed_reg, door_closed_next;
  logic          moving_reg, moving_next;
  logic          fault_reg, fault_next;
  logic [N-1:0]  floor_sensor_reg, floor_sensor_next;
  logic [N-1:0]  onehot_next;

  logic up_only, down_only, any_motor, fault_set;

  assign up_only   = motor_up & ~motor_down;
  assign down_only = motor_down & ~motor_up;
  assign any_motor = motor_up | motor_down;

  // Illegal commands are flagged here; the state machine simply never acts on them.
  assign fault_set = (motor_up & motor_down)
                   | (any_motor & ~door_closed_reg)
                   | ((state_reg == IDLE) & motor_up & (car_floor_reg == TOP_FLOOR))
                   | ((state_reg == IDLE) & motor_down & (car_floor_reg == '0))
                   | ((state_reg == MOVE_UP) & motor_down)
                   | ((state_reg == MOVE_DOWN) & motor_up);

  always_comb begin
    state_next       = state_reg;
    tcnt_next        = tcnt_reg;
    dcnt_next        = dcnt_reg;
    car_floor_next   = car_floor_reg;
    door_open_next   = door_open_reg;
    door_closed_next = door_closed_reg;
    moving_next      = moving_reg;
    fault_next       = fault_reg | fault_set;
    case (state_reg)
      IDLE: begin
        if (up_only && (car_floor_reg != TOP_FLOOR)) begin
          state_next  = MOVE_UP;
          tcnt_next   = T_LOAD;
          moving_next = 1'b1;
        end else if (down_only && (car_floor_reg != '0)) begin
          state_next  = MOVE_DOWN;
          tcnt_next   = T_LOAD;
          moving_next = 1'b1;
        end else if (open_door) begin
          state_next       = OPENING;
          dcnt_next        = D_LOAD;
          door_closed_next = 1'b0;
        end
      end
      MOVE_UP: begin
        if (up_only) begin
          if (tcnt_reg == '0) begin
            car_floor_next = car_floor_reg + PW'(1);
            moving_next    = 1'b0;
            state_next     = IDLE;
          end else begin
            tcnt_next = tcnt_reg - CW'(1);
          end
        end
      end
      MOVE_DOWN: begin
        if (down_only) begin
          if (tcnt_reg == '0) begin
            car_floor_next = car_floor_reg - PW'(1);
            moving_next    = 1'b0;
            state_next     = IDLE;
          end else begin
            tcnt_next = tcnt_reg - CW'(1);
          end
        end
      end
      OPENING: begin
        // A reversal always restarts the full door time.
        if (!open_door || close_door) begin
          state_next = CLOSING;
          dcnt_next  = D_LOAD;
        end else if (dcnt_reg == '0) begin
          state_next     = OPENED;
          door_open_next = 1'b1;
        end else begin
          dcnt_next = dcnt_reg - CW'(1);
        end
      end
      OPENED: begin
        if (!open_door || close_door) begin
          state_next     = CLOSING;
          dcnt_next      = D_LOAD;
          door_open_next = 1'b0;
        end
      end
      CLOSING: begin
        if (open_door && !close_door) begin
          state_next = OPENING;
          dcnt_next  = D_LOAD;
        end else if (dcnt_reg == '0) begin
          state_next       = IDLE;
          door_closed_next = 1'b1;
        end else begin
          dcnt_next = dcnt_reg - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign onehot_next[gi] = (car_floor_next == PW'(gi));
  end

`ifdef ELEVATOR_FLOOR_GAP_EN
  assign floor_sensor_next = moving_next ? '0 : onehot_next;
`else
  assign floor_sensor_next = onehot_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      tcnt_reg         <= '0;
      dcnt_reg         <= '0;
      car_floor_reg    <= '0;
      door_open_reg    <= 1'b0;
      door_closed_reg  <= 1'b1;
      moving_reg       <= 1'b0;
      fault_reg        <= 1'b0;
      floor_sensor_reg <= {{(N-1){1'b0}}, 1'b1};
    end else begin
      state_reg        <= state_next;
      tcnt_reg         <= tcnt_next;
      dcnt_reg         <= dcnt_next;
      car_floor_reg    <= car_floor_next;
      door_open_reg    <= door_open_next;
      door_closed_reg  <= door_closed_next;
      moving_reg       <= moving_next;
      fault_reg        <= fault_next;
      floor_sensor_reg <= floor_sensor_next;
    end
  end

  assign floor_sensor = floor_sensor_reg;
  assign car_floor    = car_floor_reg;
  assign door_open    = door_open_reg;
  assign door_closed  = door_closed_reg;
  assign moving       = moving_reg;
  assign fault        = fault_reg;

endmodule

// File: tb/tb_elevator_car_model.sv
// Directed bench for elevator_car_model (N=8, TRAVEL_CYCLES=16, DOOR_CYCLES=8).
// Status snapshot: {car_floor[2:0], floor_sensor[7:0], moving, door_open, door_closed, fault}.
module tb_elevator_car_model;

  localparam int TRV = 16;

`ifdef ELEVATOR_FLOOR_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       motor_up = 1'b0, motor_down = 1'b0, open_door = 1'b0, close_door = 1'b0;
  logic [7:0] floor_sensor;
  logic [2:0] car_floor;
  logic       door_open, door_closed, moving, fault;

  int checks = 0;
  int errors = 0;
  logic [14:0] e;

  elevator_car_model #(.N(8), .TRAVEL_CYCLES(TRV), .DOOR_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .motor_up(motor_up), .motor_down(motor_down),
    .open_door(open_door), .close_door(close_door),
    .floor_sensor(floor_sensor), .car_floor(car_floor),
    .door_open(door_open), .door_closed(door_closed),
    .moving(moving), .fault(fault)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] st();
    return {car_floor, floor_sensor, moving, door_open, door_closed, fault};
  endfunction

  // Expected snapshot: sensor is one-hot of the floor, or zero while moving in the gap build.
  function automatic logic [14:0] exp_st(int cf, bit mv, bit dop, bit dcl, bit flt);
    logic [7:0] sens;
    sens = (GAP && mv) ? 8'h00 : (8'h01 << cf);
    return {cf[2:0], sens, mv, dop, dcl, flt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    motor_up = 1'b0; motor_down = 1'b0; open_door = 1'b0; close_door = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic move_up_floors(int n);
    motor_up = 1'b1;
    repeat ((TRV + 1) * n) tick();
    motor_up = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    e = exp_st(0, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL reset_state: got %h expected %h", st(), e); end
    motor_up = 1'b1;
    tick(); tick();
    e = exp_st(0, 1, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL reset_pre_travel: got %h expected %h", st(), e); end
    #2 rst_n = 1'b0;
    #1;
    e = exp_st(0, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL reset_async_mid_travel: got %h expected %h", st(), e); end
    motor_up = 1'b0;
    tick();
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_travel();
    do_reset();
    motor_up = 1'b1;
    tick();
    e = exp_st(0, 1, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL travel_start: got %h expected %h", st(), e); end
    for (int i = 0; i < TRV - 1; i++) begin
      tick();
      checks++; if (st() !== e) begin errors++; $display("FAIL travel_mid%0d: got %h expected %h", i, st(), e); end
    end
    tick();
    e = exp_st(1, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL travel_arrive: got %h expected %h", st(), e); end
    tick();
    e = exp_st(1, 1, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL back_to_back_start: got %h expected %h", st(), e); end
    motor_up = 1'b0;
    tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL back_to_back_pause: got %h expected %h", st(), e); end
    $display("test_travel done");
  endtask

  task automatic test_door();
    do_reset();
    move_up_floors(3);
    e = exp_st(3, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL door_at_floor3: got %h expected %h", st(), e); end
    open_door = 1'b1;
    tick();
    e = exp_st(3, 0, 0, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL door_opening_start: got %h expected %h", st(), e); end
    repeat (7) tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL door_opening_end: got %h expected %h", st(), e); end
    tick();
    e = exp_st(3, 0, 1, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL door_opened: got %h expected %h", st(), e); end
    repeat (11) tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL door_held: got %h expected %h", st(), e); end
    open_door = 1'b0; close_door = 1'b1;
    tick();
    close_door = 1'b0;
    e = exp_st(3, 0, 0, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL door_closing_start: got %h expected %h", st(), e); end
    repeat (7) tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL door_closing_end: got %h expected %h", st(), e); end
    tick();
    e = exp_st(3, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL door_closed: got %h expected %h", st(), e); end
    $display("test_door done");
  endtask

  task automatic test_fault_door_open();
    do_reset();
    move_up_floors(2);
    open_door = 1'b1;
    repeat (9) tick();
    e = exp_st(2, 0, 1, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL fdoor_opened: got %h expected %h", st(), e); end
    motor_down = 1'b1;
    tick();
    motor_down = 1'b0;
    e = exp_st(2, 0, 1, 0, 1);
    checks++; if (st() !== e) begin errors++; $display("FAIL fdoor_fault: got %h expected %h", st(), e); end
    tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL fdoor_sticky: got %h expected %h", st(), e); end
    open_door = 1'b0;
    $display("test_fault_door_open done");
  endtask

  task automatic test_pause();
    do_reset();
    motor_up = 1'b1;
    repeat (11) tick();
    motor_up = 1'b0;
    repeat (10) tick();
    e = exp_st(0, 1, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL pause_hold: got %h expected %h", st(), e); end
    motor_up = 1'b1;
    repeat (5) tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL pause_resume: got %h expected %h", st(), e); end
    tick();
    motor_up = 1'b0;
    e = exp_st(1, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL pause_arrive: got %h expected %h", st(), e); end
    $display("test_pause done");
  endtask

  task automatic test_reopen();
    do_reset();
    open_door = 1'b1;
    repeat (9) tick();
    open_door = 1'b0;
    tick();
    repeat (3) tick();
    e = exp_st(0, 0, 0, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL reopen_closing: got %h expected %h", st(), e); end
    open_door = 1'b1;
    tick();
    repeat (7) tick();
    checks++; if (st() !== e) begin errors++; $display("FAIL reopen_not_yet: got %h expected %h", st(), e); end
    tick();
    e = exp_st(0, 0, 1, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL reopen_opened: got %h expected %h", st(), e); end
    close_door = 1'b1;
    tick();
    repeat (7) tick();
    e = exp_st(0, 0, 0, 0, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL close_wins_closing: got %h expected %h", st(), e); end
    open_door = 1'b0; close_door = 1'b0;
    tick();
    e = exp_st(0, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL close_wins_closed: got %h expected %h", st(), e); end
    $display("test_reopen done");
  endtask

  task automatic test_limits();
    do_reset();
    motor_down = 1'b1;
    tick();
    motor_down = 1'b0;
    e = exp_st(0, 0, 0, 1, 1);
    checks++; if (st() !== e) begin errors++; $display("FAIL limit_bottom: got %h expected %h", st(), e); end
    do_reset();
    motor_up = 1'b1; motor_down = 1'b1;
    tick();
    motor_up = 1'b0; motor_down = 1'b0;
    checks++; if (st() !== e) begin errors++; $display("FAIL limit_both_motors: got %h expected %h", st(), e); end
    do_reset();
    move_up_floors(7);
    e = exp_st(7, 0, 0, 1, 0);
    checks++; if (st() !== e) begin errors++; $display("FAIL limit_floor7: got %h expected %h", st(), e); end
    motor_up = 1'b1;
    tick(); tick();
    motor_up = 1'b0;
    e = exp_st(7, 0, 0, 1, 1);
    checks++; if (st() !== e) begin errors++; $display("FAIL limit_top: got %h expected %h", st(), e); end
    $display("test_limits done");
  endtask

  task automatic test_floor_gap();
    do_reset();
    motor_up = 1'b1;
    for (int ed = 1; ed <= 2 * (TRV + 1); ed++) begin
      tick();
      e = exp_st(ed / (TRV + 1), (ed % (TRV + 1)) != 0, 0, 1, 0);
      checks++; if (st() !== e) begin errors++; $display("FAIL gap_edge%0d: got %h expected %h", ed, st(), e); end
    end
    motor_up = 1'b0;
    $display("test_floor_gap done");
  endtask

  initial begin
    test_reset();
    test_travel();
    test_door();
    test_fault_door_open();
    test_pause();
    test_reopen();
    test_limits();
    test_floor_gap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
